// File: rtl/dut_stream_driver_if.sv
// Handshake and serial bundle between the PRBS stream driver and its environment.
// The driver takes the master modport: it sources d_in and the status outputs.
// The environment (DAC demo top or bench) takes the slave modport.
interface dut_stream_driver_if;
    logic       start;
    logic       d_in;
    logic       d_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;

    modport master (
        input  start,
        input  d_out,
        output d_in,
        output busy,
        output done,
        output pass,
        output err_count
    );

    modport slave (
        output start,
        output d_out,
        input  d_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count
    );
endinterface

// File: rtl/dut_stream_driver.sv
// PRBS stream driver for the dut serial path.
// Each accepted start sends ITERS bits from an 8-bit Fibonacci LFSR
// (x^8+x^6+x^5+x^4+1, seed reloaded per burst). It then waits LATENCY
// cycles so the echo can drain, and pulses done for one cycle.
// Every echoed bit is compared with a delayed copy of the transmitted bit.
// Mismatches are counted in a counter that saturates at 255.
module dut_stream_driver #(
    parameter int         ITERS   = 20,
    parameter int         LATENCY = 2,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    dut_stream_driver_if.master bus
);

    // Reject parameter values that cannot describe a working burst.
    if (ITERS < 1) begin : g_bad_iters
        $error("dut_stream_driver: ITERS must be >= 1");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("dut_stream_driver: LATENCY must be >= 1");
    end
    if (SEED == 8'h00) begin : g_bad_seed
        $error("dut_stream_driver: SEED must be non-zero (LFSR lock-up)");
    end

    localparam int BCNT_W = $clog2(ITERS + 1);
    localparam int DCNT_W = $clog2(LATENCY + 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(ITERS);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                w_load;       // start accepted: this edge sends bit 0
    logic                w_emit;       // SEND continues: this edge sends the next bit
    logic                w_tx_vld;     // a burst bit is launched onto d_in this edge
    logic                w_tx_bit;     // value of that bit
    logic                w_cmp_en;
    logic                w_mismatch;
    logic [7:0]          w_err_nxt;
    logic                w_drain_exit;

    logic [7:0]          r_lfsr;
    logic [BCNT_W-1:0]   r_bcnt;       // bits launched so far in this burst
    logic [DCNT_W-1:0]   r_dcnt;       // cycles spent in DRAIN
    logic                r_d_in;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [7:0]          r_err;
    logic [LATENCY:0]    r_exp;        // transmitted bits, aligned to the echo by the tap
    logic [LATENCY:0]    r_vld;        // marks which r_exp entries are real burst bits

    // One Fibonacci step. The new bit enters at the top; bit 0 is the output.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
    endfunction

    // Saturating error increment, so a long bad burst parks at 255.
    function automatic logic [7:0] err_inc(input logic [7:0] e);
        return (e == 8'hFF) ? e : e + 8'd1;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-edge control strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_emit       = 1'b0;
        w_drain_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SEND;
                    w_load      = 1'b1;
                end
            end
            S_SEND: begin
                if (r_bcnt == BCNT_LAST) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_emit = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_dcnt == DCNT_LAST) begin
                    w_state_nxt  = S_DONE;
                    w_drain_exit = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_tx_vld = w_load | w_emit;
    assign w_tx_bit = w_load ? SEED[0] : r_lfsr[0];

    // The echo tap is only trusted while a burst is in flight. DONE never compares.
    assign w_cmp_en   = r_vld[LATENCY] & ((r_state == S_SEND) | (r_state == S_DRAIN));
    assign w_mismatch = w_cmp_en & (bus.d_out != r_exp[LATENCY]);
    assign w_err_nxt  = w_mismatch ? err_inc(r_err) : r_err;

    // LFSR and bit counter. A start reloads the seed, so every burst is identical.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
            r_bcnt <= '0;
        end else if (w_load) begin
            r_lfsr <= lfsr_step(SEED);
            r_bcnt <= BCNT_W'(1);
        end else if (w_emit) begin
            r_lfsr <= lfsr_step(r_lfsr);
            r_bcnt <= r_bcnt + BCNT_W'(1);
        end
    end

    // Drain counter. It runs only in DRAIN and stops at its last value, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt <= '0;
        end else if (r_state != S_DRAIN) begin
            r_dcnt <= '0;
        end else if (r_dcnt != DCNT_LAST) begin
            r_dcnt <= r_dcnt + DCNT_W'(1);
        end
    end

    // Serial output plus the expected-bit/valid delay lines that line up with the echo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_in <= 1'b0;
            r_exp  <= '0;
            r_vld  <= '0;
        end else begin
            r_d_in <= w_tx_vld ? w_tx_bit : 1'b0;
            r_exp  <= {r_exp[LATENCY-1:0], w_tx_bit};
            r_vld  <= {r_vld[LATENCY-1:0], w_tx_vld};
        end
    end

    // Status: busy, the done pulse, the error count, and pass.
    // pass uses the post-compare count, so it includes the final echoed bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 8'd0;
            r_pass <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_SEND) | (w_state_nxt == S_DRAIN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_load) begin
                r_err  <= 8'd0;
                r_pass <= 1'b0;
            end else begin
                r_err <= w_err_nxt;
                if (w_drain_exit) begin
                    r_pass <= (w_err_nxt == 8'd0);
                end
            end
        end
    end

    assign bus.d_in      = r_d_in;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;

endmodule

// File: tb/tb_dut_stream_driver.sv
// Bench for dut_stream_driver.
// Instance A uses the default parameters. Its echo is a modelled dut with
// selectable behaviour: delay 2, delay 3, or tied 0.
// Instance B uses ITERS=300 with an inverted echo, which drives the error count into saturation.
// The expected PRBS is built from the polynomial recurrence
// s[n+8] = s[n]^s[n+2]^s[n+3]^s[n+4].
`timescale 1ns/1ps
module tb_dut_stream_driver;
    localparam int         IT_A = 20;
    localparam int         IT_B = 300;
    localparam int         LAT  = 2;
    localparam logic [7:0] SEED = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_na;
    logic rst_nb;
    int   cyc = 0;                      // number of posedges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    dut_stream_driver_if ifa();
    dut_stream_driver_if ifb();

    dut_stream_driver #(.ITERS(IT_A), .LATENCY(LAT), .SEED(SEED)) u_a (
        .clk(clk), .rst_n(rst_na), .bus(ifa));
    dut_stream_driver #(.ITERS(IT_B), .LATENCY(LAT), .SEED(SEED)) u_b (
        .clk(clk), .rst_n(rst_nb), .bus(ifb));

    // Echo models: register chains standing in for the dut
    int         mode_a;                 // 0: delay 2, 1: delay 3, 2: tied 0
    logic [3:0] sha;
    logic [3:0] shb;
    always @(posedge clk or negedge rst_na)
        if (!rst_na) sha <= '0; else sha <= {sha[2:0], ifa.d_in};
    always @(posedge clk or negedge rst_nb)
        if (!rst_nb) shb <= '0; else shb <= {shb[2:0], ifb.d_in};
    assign ifa.d_out = (mode_a == 0) ? sha[1] : (mode_a == 1) ? sha[2] : 1'b0;
    assign ifb.d_out = ~shb[1];

    // Bookkeeping
    int n_vec = 0;
    int n_err = 0;
    bit seq [0:IT_B+7];

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model for instance A
    typedef struct { int k; int err; int pass; } exp_t;
    exp_t sb_a[$];
    int   a_k = -1;                     // edge of the most recently accepted start
    int   a_free = 0;                   // first edge at which a start is accepted again
    int   a_pass_hold = 0;

    // Count mismatches between each sent bit and what the echo shows at its compare point.
    // An echo of delay D presents sent bit (i+LAT-D) when bit i is checked. d_in is 0 outside the burst.
    function automatic int exp_err_a(input int m);
        int e;
        int j;
        int rb;
        e = 0;
        for (int i = 0; i < IT_A; i++) begin
            if (m == 2) rb = 0;
            else begin
                j  = i + LAT - ((m == 0) ? 2 : 3);
                rb = (j >= 0 && j < IT_A) ? int'(seq[j]) : 0;
            end
            if (rb != int'(seq[i])) e++;
        end
        return (e > 255) ? 255 : e;
    endfunction

    task automatic model_start_a(input int e);
        exp_t ent;
        if (e >= a_free) begin
            a_k      = e;
            a_free   = e + IT_A + LAT + 2;
            ent.k    = e;
            ent.err  = exp_err_a(mode_a);
            ent.pass = (ent.err == 0) ? 1 : 0;
            sb_a.push_back(ent);
        end
    endtask

    // Drive start for the next edge and let the model see the request
    task automatic tick_a(input bit st);
        @(negedge clk);
        ifa.start = st;
        if (st) model_start_a(cyc + 1);
    endtask

    task automatic run_burst_a(input int m);
        while (cyc + 1 < a_free) tick_a(1'b0);
        mode_a = m;
        tick_a(1'b1);
        repeat (IT_A + LAT + 4) tick_a(1'b0);
    endtask

    // Monitor A: per-cycle stream/status checks and the scoreboard pop on done
    int   ma_win;
    int   ma_din;
    exp_t ma_ent;
    always @(negedge clk) begin
        if (rst_na) begin
            ma_win = (a_k >= 0 && cyc >= a_k && cyc < a_k + IT_A + LAT) ? 1 : 0;
            ma_din = (a_k >= 0 && cyc >= a_k && cyc < a_k + IT_A) ? int'(seq[cyc - a_k]) : 0;
            check("busy_a", ifa.busy, ma_win);
            check("d_in_a", ifa.d_in, ma_din);
            if (ifa.done) begin
                if (sb_a.size() == 0) check("done_unexpected_a", ifa.done, 0);
                else begin
                    ma_ent = sb_a.pop_front();
                    check("done_edge_a", cyc, ma_ent.k + IT_A + LAT);
                    check("err_count_a", ifa.err_count, ma_ent.err);
                    check("pass_a", ifa.pass, ma_ent.pass);
                    a_pass_hold = ma_ent.pass;
                end
            end else begin
                if (sb_a.size() > 0 && cyc >= sb_a[0].k + IT_A + LAT) begin
                    check("done_missing_a", ifa.done, 1);
                    void'(sb_a.pop_front());
                end
                check("pass_level_a", ifa.pass, (ma_win != 0) ? 0 : a_pass_hold);
            end
        end
    end

    // Monitor B: saturating error count, busy window, single done
    int kb = -1;
    int b_fin = 0;
    int mb_n;
    always @(negedge clk) begin
        if (rst_nb && kb >= 0 && cyc >= kb && cyc <= kb + IT_B + LAT + 8) begin
            mb_n = cyc - kb - LAT;
            if (mb_n < 0) mb_n = 0;
            if (mb_n > IT_B) mb_n = IT_B;
            if (mb_n > 255) mb_n = 255;
            check("err_count_b", ifb.err_count, mb_n);
            check("busy_b", ifb.busy, (cyc < kb + IT_B + LAT) ? 1 : 0);
            check("done_b", ifb.done, (cyc == kb + IT_B + LAT) ? 1 : 0);
            if (cyc == kb + IT_B + LAT) check("pass_b", ifb.pass, 0);
        end
    end

    // Instance B stimulus
    initial begin
        ifb.start = 1'b0;
        rst_nb = 1'b1;
        #1 rst_nb = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy_b", ifb.busy, 0);
        check("rst_err_b", ifb.err_count, 0);
        rst_nb = 1'b1;
        @(negedge clk);
        ifb.start = 1'b1;
        kb = cyc + 1;
        @(negedge clk);
        ifb.start = 1'b0;
        while (cyc < kb + IT_B + LAT + 10) @(negedge clk);
        b_fin = 1;
    end

    // Instance A stimulus
    initial begin
        logic [7:0] sd;
        int         guard;
        sd = SEED;
        for (int j = 0; j < 8; j++) seq[j] = sd[j];
        for (int n = 0; n < IT_B; n++) seq[n+8] = seq[n] ^ seq[n+2] ^ seq[n+3] ^ seq[n+4];

        mode_a    = 0;
        ifa.start = 1'b0;
        rst_na    = 1'b1;
        #1 rst_na = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_d_in_a", ifa.d_in, 0);
        check("rst_busy_a", ifa.busy, 0);
        check("rst_done_a", ifa.done, 0);
        check("rst_pass_a", ifa.pass, 0);
        check("rst_err_a", ifa.err_count, 0);
        rst_na = 1'b1;
        repeat (4) tick_a(1'b0);

        // T1 clean echo, T2 one-cycle-late echo, T3 echo tied low
        run_burst_a(0);
        run_burst_a(1);
        run_burst_a(2);

        // T4: re-pulse while busy and at the DONE entry, then hold start high
        mode_a = 0;
        tick_a(1'b1);
        for (int e = 1; e <= 60; e++) tick_a((e == 5) || (e >= 22 && e < 60));
        repeat (30) tick_a(1'b0);

        // T5: asynchronous reset mid-SEND, then a normal burst
        tick_a(1'b1);
        repeat (9) tick_a(1'b0);
        @(posedge clk);
        #1;
        rst_na    = 1'b0;
        ifa.start = 1'b0;
        sb_a.delete();
        a_k = -1;
        a_free = 0;
        a_pass_hold = 0;
        #1;
        check("midrst_d_in_a", ifa.d_in, 0);
        check("midrst_busy_a", ifa.busy, 0);
        check("midrst_err_a", ifa.err_count, 0);
        check("midrst_pass_a", ifa.pass, 0);
        check("midrst_done_a", ifa.done, 0);
        repeat (3) @(negedge clk);
        rst_na = 1'b1;
        repeat (2) tick_a(1'b0);
        run_burst_a(0);

        // Randomized start traffic across echo modes
        for (int r = 0; r < 8; r++) begin
            while (cyc + 1 < a_free) tick_a(1'b0);
            mode_a = $urandom_range(0, 2);
            repeat (40) tick_a($urandom_range(0, 3) == 0);
        end
        while (cyc + 1 < a_free) tick_a(1'b0);
        repeat (4) tick_a(1'b0);

        guard = 0;
        while (b_fin == 0 && guard < 2000) begin
            tick_a(1'b0);
            guard++;
        end
        if (b_fin == 0) check("b_finish_timeout", b_fin, 1);
        check("sb_a_drained", sb_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got edge %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
